ifetch_arbiter: RTL

Sequences all accesses to the combinational instruction memory (byte address, base 0x00400000, 2048 words). Owns the fetch PC and buffers fetched {pc, inst} pairs in a small prefetch queue for the decode stage. Shares the memory port with a debug/loader read requester through a round-robin arbiter. Sits between the PC/branch logic and the IF/ID pipeline register.

---
 rtl/ifetch_if.sv | 29 ++
 rtl/ifetch_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ifetch_if.sv
// Bundles the fetch arbiter's memory, decode-queue and debug signals.
// master = arbiter side, slave = surrounding pipeline / memory / debug side.
interface ifetch_if;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic [31:0] dbg_data;
  logic        busy;

  modport master (
    input  halt, redirect_valid, redirect_pc, imem_inst, out_ready, dbg_req, dbg_addr,
    output imem_addr, out_valid, out_pc, out_inst, out_err, dbg_gnt, dbg_data, busy
  );

  modport slave (
    output halt, redirect_valid, redirect_pc, imem_inst, out_ready, dbg_req, dbg_addr,
    input  imem_addr, out_valid, out_pc, out_inst, out_err, dbg_gnt, dbg_data, busy
  );
endinterface

// File: rtl/ifetch_arbiter.sv
// Instruction-fetch sequencer: owns the fetch PC, round-robins the imem port with a debug reader,
// and buffers {pc, inst, err} in a prefetch queue. Define IFETCH_RANGE_CHECK_EN to flag out-of-range fetches.
module ifetch_arbiter #(
  parameter logic [31:0] RESET_PC  = 32'h00400000,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MEM_BASE  = 32'h00400000,
  parameter int          MEM_WORDS = 2048
) (
  input  logic    clk,
  input  logic    rst_n,
  ifetch_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] MEM_END = MEM_BASE + 32'(4 * MEM_WORDS);

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || MEM_WORDS < 1
      || MEM_BASE[1:0] != 2'b00 || MEM_END <= MEM_BASE) begin : g_bad_cfg
    $error("ifetch_arbiter: unsupported DEPTH or memory window");
  end

  typedef enum logic [1:0] {RUN, STALL, HALTED} fetch_state_t;
  fetch_state_t state_reg, state_next;

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, head_idx;
  logic          fetch_turn_reg;  // 1: fetch wins the next contention
  logic          out_valid_reg, out_err_reg;
  logic [31:0]   out_pc_reg, out_inst_reg;

  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic        q_err  [DEPTH];

  logic        pop, fetch_want, fetch_gnt, dbg_gnt_c, dbg_want, contention, bypass;
  logic        fetch_err, dbg_err;
  logic [31:0] fetch_inst, head_pc, head_inst;
  logic        head_err;

`ifdef IFETCH_RANGE_CHECK_EN
  assign fetch_err = (fetch_pc_reg < MEM_BASE) || (fetch_pc_reg >= MEM_END);
  assign dbg_err   = (bus.dbg_addr < MEM_BASE) || (bus.dbg_addr >= MEM_END);
`else
  assign fetch_err = 1'b0;
  assign dbg_err   = 1'b0;
`endif
  assign fetch_inst = fetch_err ? 32'h0 : bus.imem_inst;

  always_comb begin
    state_next    = state_reg;
    pop           = out_valid_reg && bus.out_ready;
    fetch_want    = !bus.halt && !bus.redirect_valid && ((count_reg < CW'(DEPTH)) || pop);
    dbg_want      = bus.dbg_req && rst_n;
    contention    = fetch_want && dbg_want;
    dbg_gnt_c     = contention ? !fetch_turn_reg : dbg_want;
    fetch_gnt     = fetch_want && !dbg_gnt_c;
    fetch_pc_next = fetch_pc_reg;
    if (bus.redirect_valid)
      fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
    else if (fetch_gnt)
      fetch_pc_next = fetch_pc_reg + 32'd4;

    if (bus.halt)
      state_next = HALTED;
    else if (state_reg == HALTED || bus.redirect_valid || fetch_gnt)
      state_next = RUN;
    else
      state_next = STALL;
  end

  // New head comes straight from the push when the queue is (or is about to be) empty.
  always_comb begin
    count_next = count_reg + CW'(fetch_gnt) - CW'(pop);
    head_idx   = rd_ptr_reg + PW'(pop);
    bypass     = (count_reg == CW'(pop));
    head_pc    = bypass ? fetch_pc_reg : q_pc[head_idx];
    head_inst  = bypass ? fetch_inst   : q_inst[head_idx];
    head_err   = bypass ? fetch_err    : q_err[head_idx];
  end

  always_ff @(posedge clk) begin
    if (fetch_gnt) begin
      q_pc[wr_ptr_reg]   <= fetch_pc_reg;
      q_inst[wr_ptr_reg] <= fetch_inst;
      q_err[wr_ptr_reg]  <= fetch_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      fetch_pc_reg   <= RESET_PC;
      count_reg      <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      fetch_turn_reg <= 1'b1;
      out_valid_reg  <= 1'b0;
      out_pc_reg     <= '0;
      out_inst_reg   <= '0;
      out_err_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (contention)
        fetch_turn_reg <= dbg_gnt_c;
      if (bus.redirect_valid) begin
        count_reg     <= '0;
        rd_ptr_reg    <= '0;
        wr_ptr_reg    <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        count_reg     <= count_next;
        out_valid_reg <= (count_next != '0);
        if (fetch_gnt)
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        if (count_next != '0) begin
          out_pc_reg   <= head_pc;
          out_inst_reg <= head_inst;
          out_err_reg  <= head_err;
        end
      end
    end
  end

  assign bus.imem_addr = dbg_gnt_c ? bus.dbg_addr : fetch_pc_reg;
  assign bus.dbg_gnt   = dbg_gnt_c;
  assign bus.dbg_data  = (dbg_gnt_c && !dbg_err) ? bus.imem_inst : 32'h0;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_pc    = out_pc_reg;
  assign bus.out_inst  = out_inst_reg;
  assign bus.out_err   = out_err_reg;
  assign bus.busy      = (count_reg != '0) || !bus.halt;
endmodule
